// File: rtl/div_pkg.sv
// Shared types and constants for the HI/LO divide sequencer and its helpers.
package div_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        FIX,
        DONE
    } state_e;

    localparam int          CNT_W        = 8;
    localparam logic [31:0] DBZ_QUOTIENT = 32'hFFFF_FFFF;

endpackage

// File: rtl/neg_if.sv
// Conditional two's-complement negate; wraps, so -0x80000000 stays 0x80000000.
module neg_if (
    input  logic        neg,
    input  logic [31:0] in_val,
    output logic [31:0] out_val
);

    assign out_val = neg ? (~in_val + 32'd1) : in_val;

endmodule

// File: rtl/div_hilo_sequencer.sv
// Drives operand magnitudes into an external combinational divider, waits out its
// multicycle settle window, then sign-corrects quotient/remainder into LO/HI.
module div_hilo_sequencer
    import div_pkg::*;
#(
    parameter int SETTLE_CYCLES = 4
) (
    input  logic        clock,
    input  logic        clear,
    input  logic        start,
    input  logic        is_signed,
    input  logic [31:0] op_a,
    input  logic [31:0] op_b,
    output logic [31:0] div_dividend,
    output logic [31:0] div_divisor,
    input  logic [31:0] div_quotient,
    input  logic [31:0] div_remainder,
    output logic        busy,
    output logic        done,
    output logic        dbz,
    output logic [31:0] hi_out,
    output logic [31:0] lo_out
);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               sign_a_q, sign_a_d;
    logic               sign_b_q, sign_b_d;
    logic               dbz_q, dbz_d;
    logic [31:0]        a_q, a_d;
    logic [31:0]        dividend_q, dividend_d;
    logic [31:0]        divisor_q, divisor_d;
    logic [31:0]        hi_q, hi_d;
    logic [31:0]        lo_q, lo_d;

    logic               sign_a_in, sign_b_in;
    logic [31:0]        mag_a, mag_b, quo_fixed, rem_fixed;

    assign sign_a_in = op_a[31] & is_signed;
    assign sign_b_in = op_b[31] & is_signed;

    neg_if u_neg_a (.neg(sign_a_in),           .in_val(op_a),          .out_val(mag_a));
    neg_if u_neg_b (.neg(sign_b_in),           .in_val(op_b),          .out_val(mag_b));
    // Quotient is negative when operand signs differ; remainder follows the dividend.
    neg_if u_fix_q (.neg(sign_a_q ^ sign_b_q), .in_val(div_quotient),  .out_val(quo_fixed));
    neg_if u_fix_r (.neg(sign_a_q),            .in_val(div_remainder), .out_val(rem_fixed));

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        sign_a_d   = sign_a_q;
        sign_b_d   = sign_b_q;
        dbz_d      = dbz_q;
        a_d        = a_q;
        dividend_d = dividend_q;
        divisor_d  = divisor_q;
        hi_d       = hi_q;
        lo_d       = lo_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    sign_a_d   = sign_a_in;
                    sign_b_d   = sign_b_in;
                    a_d        = op_a;
                    dividend_d = mag_a;
                    divisor_d  = mag_b;
                    dbz_d      = (op_b == '0);
                    if (op_b == '0) begin
                        state_d = FIX;
                    end else begin
                        state_d = SETTLE;
                        cnt_d   = CNT_W'(SETTLE_CYCLES - 1);
                    end
                end
            end
            SETTLE: begin
                if (cnt_q == '0) begin
                    state_d = FIX;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            FIX: begin
                // Divide-by-zero bypasses the divider; HI returns the original dividend.
                if (dbz_q) begin
                    lo_d = DBZ_QUOTIENT;
                    hi_d = a_q;
                end else begin
                    lo_d = quo_fixed;
                    hi_d = rem_fixed;
                end
                state_d = DONE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only; every flop, including
    // HI/LO and the operand latches, is cleared so an aborted operation leaves no trace.
    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            sign_a_q   <= 1'b0;
            sign_b_q   <= 1'b0;
            dbz_q      <= 1'b0;
            a_q        <= '0;
            dividend_q <= '0;
            divisor_q  <= '0;
            hi_q       <= '0;
            lo_q       <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            sign_a_q   <= sign_a_d;
            sign_b_q   <= sign_b_d;
            dbz_q      <= dbz_d;
            a_q        <= a_d;
            dividend_q <= dividend_d;
            divisor_q  <= divisor_d;
            hi_q       <= hi_d;
            lo_q       <= lo_d;
        end
    end

    assign div_dividend = dividend_q;
    assign div_divisor  = divisor_q;
    assign busy         = (state_q == SETTLE) || (state_q == FIX);
    assign done         = (state_q == DONE);
    assign dbz          = dbz_q;
    assign hi_out       = hi_q;
    assign lo_out       = lo_q;

endmodule
